// File: rtl/scld_pix_packer_pkg.sv
// Shared types and constants for the scaled-pixel packer: scale encodings,
// address/data widths, default base addresses and the round-robin helper.
package scld_pix_packer_pkg;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 32;
  localparam int N_SCALES = 3;

  localparam logic [ADDR_W-1:0] BASE_1_DEF = 19'h00000;
  localparam logic [ADDR_W-1:0] BASE_2_DEF = 19'h14000;
  localparam logic [ADDR_W-1:0] BASE_4_DEF = 19'h19000;

  typedef enum logic [1:0] {
    SCALE_1 = 2'd0,
    SCALE_2 = 2'd1,
    SCALE_4 = 2'd2
  } scale_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

  // Pick the first pending scale strictly after 'last' in x1, x2, x4 order.
  // Walking the offsets from lowest to highest priority lets the nearest one win.
  function automatic scale_e rr_pick(input logic [N_SCALES-1:0] pend, input scale_e last);
    scale_e     pick;
    logic [1:0] idx;
    pick = last;
    for (int k = N_SCALES; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % N_SCALES);
      if (pend[idx]) pick = scale_e'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/scld_word_fifo.sv
// Small synchronous FIFO holding packed words with their write addresses.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module scld_word_fifo
  import scld_pix_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  word_t push_word_i,
  input  logic  pop_i,
  output word_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  word_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide
  // which entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word_i;
  end

endmodule

// File: rtl/scld_pix_packer.sv
// Packs 8-bit gray pixels from three scaler outputs into 32-bit words, buffers
// each scale in its own FIFO and writes them out through a round-robin arbiter.
module scld_pix_packer
  import scld_pix_packer_pkg::*;
#(
  parameter int                H_PIX      = 640,
  parameter int                V_LINES    = 480,
  parameter logic [ADDR_W-1:0] BASE_1     = BASE_1_DEF,
  parameter logic [ADDR_W-1:0] BASE_2     = BASE_2_DEF,
  parameter logic [ADDR_W-1:0] BASE_4     = BASE_4_DEF,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              tm3_clk_v0,
  input  logic              tm3_rst_n,
  input  logic              vidin_frame_start,
  input  logic              vidin_new_data_scld_1,
  input  logic              vidin_new_data_scld_2,
  input  logic              vidin_new_data_scld_4,
  input  logic [7:0]        vidin_gray_scld_1,
  input  logic [7:0]        vidin_gray_scld_2,
  input  logic [7:0]        vidin_gray_scld_4,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        mem_scale,
  output logic              frame_done_1,
  output logic              frame_done_2,
  output logic              frame_done_4,
  output logic              ovf_1,
  output logic              ovf_2,
  output logic              ovf_4
);

  localparam logic [N_SCALES-1:0][ADDR_W-1:0] BASE = {BASE_4, BASE_2, BASE_1};

  logic [N_SCALES-1:0]      px_vld;
  logic [N_SCALES-1:0][7:0] px_gray;
  logic [N_SCALES-1:0]      fifo_full;
  logic [N_SCALES-1:0]      fifo_empty;
  logic [N_SCALES-1:0]      pop;
  logic [N_SCALES-1:0]      done_vec;
  logic [N_SCALES-1:0]      ovf_vec;
  word_t                    head [N_SCALES];

  assign px_vld  = {vidin_new_data_scld_4, vidin_new_data_scld_2, vidin_new_data_scld_1};
  assign px_gray = {vidin_gray_scld_4, vidin_gray_scld_2, vidin_gray_scld_1};

  // One packer + FIFO per scale; scale index s means a 2^s downscale.
  for (genvar s = 0; s < N_SCALES; s++) begin : g_scale
    localparam int                WORDS    = ((H_PIX >> s) / 4) * (V_LINES >> s);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       partial_q, partial_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              push_q, push_d;
    logic              done_q, done_d;
    word_t             word_q, word_d;
    logic              ovf_q;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
      byte_cnt_d = vidin_frame_start ? 2'd0 : byte_cnt_q;
      idx_d      = vidin_frame_start ? '0 : idx_q;
      partial_d  = partial_q;
      word_d     = word_q;
      push_d     = 1'b0;
      done_d     = 1'b0;
      if (px_vld[s]) begin
        if (byte_cnt_d == 2'd3) begin
          push_d      = 1'b1;
          word_d.data = {px_gray[s], partial_d};
          word_d.addr = BASE[s] + idx_d;
          done_d      = (idx_d == LAST_IDX);
          idx_d       = done_d ? '0 : idx_d + 1'b1;
        end else begin
          // Shift in from the top so the first pixel ends up in the low byte.
          partial_d = {px_gray[s], partial_d[23:8]};
        end
        byte_cnt_d = byte_cnt_d + 2'd1;
      end
    end

    always_ff @(posedge tm3_clk_v0 or negedge tm3_rst_n) begin
      if (!tm3_rst_n) begin
        byte_cnt_q <= '0;
        partial_q  <= '0;
        idx_q      <= '0;
        push_q     <= 1'b0;
        done_q     <= 1'b0;
        word_q     <= '0;
        ovf_q      <= 1'b0;
      end else begin
        byte_cnt_q <= byte_cnt_d;
        partial_q  <= partial_d;
        idx_q      <= idx_d;
        push_q     <= push_d;
        done_q     <= done_d;
        word_q     <= word_d;
        if (push_q && fifo_full[s] && !pop[s]) ovf_q <= 1'b1;
      end
    end

    scld_word_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (tm3_clk_v0),
      .rst_n       (tm3_rst_n),
      .push_i      (push_q),
      .push_word_i (word_q),
      .pop_i       (pop[s]),
      .head_o      (head[s]),
      .full_o      (fifo_full[s]),
      .empty_o     (fifo_empty[s])
    );

    assign done_vec[s] = done_q;
    assign ovf_vec[s]  = ovf_q;
  end

  assign frame_done_1 = done_vec[0];
  assign frame_done_2 = done_vec[1];
  assign frame_done_4 = done_vec[2];
  assign ovf_1        = ovf_vec[0];
  assign ovf_2        = ovf_vec[1];
  assign ovf_4        = ovf_vec[2];

  arb_state_e        state_q;
  scale_e            last_q;
  scale_e            sel_q;
  scale_e            pick;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  scale_e            mem_scale_q;

  assign pick = rr_pick(~fifo_empty, last_q);

  // The FIFO head is popped only once the memory has taken the word.
  always_comb begin
    pop = '0;
    if (state_q == ARB_BUSY && mem_ack) pop[sel_q] = 1'b1;
  end

  always_ff @(posedge tm3_clk_v0 or negedge tm3_rst_n) begin
    if (!tm3_rst_n) begin
      state_q     <= ARB_IDLE;
      last_q      <= SCALE_4;
      sel_q       <= SCALE_1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_scale_q <= SCALE_1;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (!(&fifo_empty)) begin
            sel_q       <= pick;
            last_q      <= pick;
            mem_addr_q  <= head[pick].addr;
            mem_data_q  <= head[pick].data;
            mem_scale_q <= pick;
            mem_req_q   <= 1'b1;
            state_q     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_scale = mem_scale_q;

endmodule

// File: tb/tb_scld_pix_packer.sv
// Directed bench for scld_pix_packer: latency, arbitration order, overflow,
// frame wrap, frame_start realignment and reset during a pending request.
module tb_scld_pix_packer;

  logic        clk;
  logic        rst_n;
  logic        vidin_frame_start;
  logic        nd1, nd2, nd4;
  logic [7:0]  g1, g2, g4;
  logic        mem_req;
  logic        mem_ack;
  logic [18:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  mem_scale;
  logic        frame_done_1, frame_done_2, frame_done_4;
  logic        ovf_1, ovf_2, ovf_4;

  int total = 0;
  int bad   = 0;

  scld_pix_packer dut (
    .tm3_clk_v0            (clk),
    .tm3_rst_n             (rst_n),
    .vidin_frame_start     (vidin_frame_start),
    .vidin_new_data_scld_1 (nd1),
    .vidin_new_data_scld_2 (nd2),
    .vidin_new_data_scld_4 (nd4),
    .vidin_gray_scld_1     (g1),
    .vidin_gray_scld_2     (g2),
    .vidin_gray_scld_4     (g4),
    .mem_req               (mem_req),
    .mem_ack               (mem_ack),
    .mem_addr              (mem_addr),
    .mem_data              (mem_data),
    .mem_scale             (mem_scale),
    .frame_done_1          (frame_done_1),
    .frame_done_2          (frame_done_2),
    .frame_done_4          (frame_done_4),
    .ovf_1                 (ovf_1),
    .ovf_2                 (ovf_2),
    .ovf_4                 (ovf_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] vld, input logic [7:0] p1, input logic [7:0] p2,
                       input logic [7:0] p4, input logic fs);
    nd1 = vld[0]; nd2 = vld[1]; nd4 = vld[2];
    g1 = p1; g2 = p2; g4 = p4;
    vidin_frame_start = fs;
    step();
    nd1 = 1'b0; nd2 = 1'b0; nd4 = 1'b0;
    vidin_frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  // Wait (bounded) for a request, check it, hold it for two cycles, then ack.
  task automatic serve(input string tag, input logic [1:0] sc, input logic [18:0] addr,
                       input logic [31:0] data);
    int n = 0;
    while (!mem_req && n < 40) begin
      step();
      n++;
    end
    check({tag, ".req"},   32'(mem_req), 32'd1);
    check({tag, ".scale"}, 32'(mem_scale), 32'(sc));
    check({tag, ".addr"},  32'(mem_addr), 32'(addr));
    check({tag, ".data"},  mem_data, data);
    step();
    check({tag, ".req2"},  32'(mem_req), 32'd1);
    check({tag, ".addr2"}, 32'(mem_addr), 32'(addr));
    check({tag, ".data2"}, mem_data, data);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check({tag, ".drop"},  32'(mem_req), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (mem_req) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_pix;
    logic [18:0] last_addr;

    rst_n = 1'b0;
    mem_ack = 1'b0;
    vidin_frame_start = 1'b0;
    nd1 = 1'b0; nd2 = 1'b0; nd4 = 1'b0;
    g1 = '0; g2 = '0; g4 = '0;
    step();
    step();
    check("rst.req",   32'(mem_req), 32'd0);
    check("rst.addr",  32'(mem_addr), 32'd0);
    check("rst.data",  mem_data, 32'd0);
    check("rst.scale", 32'(mem_scale), 32'd0);
    check("rst.done",  32'({frame_done_1, frame_done_2, frame_done_4}), 32'd0);
    check("rst.ovf",   32'({ovf_1, ovf_2, ovf_4}), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Basic packing and 3-cycle latency with ack tied high.
    mem_ack = 1'b1;
    drive(3'b001, 8'h11, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'h22, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'h33, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'h44, 8'h00, 8'h00, 1'b0);
    step();
    check("lat.early", 32'(mem_req), 32'd0);
    step();
    check("lat.req",   32'(mem_req), 32'd1);
    check("lat.data",  mem_data, 32'h44332211);
    check("lat.addr",  32'(mem_addr), 32'h00000);
    check("lat.scale", 32'(mem_scale), 32'd0);
    step();
    check("lat.once",  32'(mem_req), 32'd0);
    quiet("lat.quiet", 4);
    mem_ack = 1'b0;

    // All three scales complete a word together: x1, x2, x4 order.
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(3'b111, 8'(8'h01 + i), 8'(8'h11 + i), 8'(8'h21 + i), 1'b0);
    serve("rr.x1", 2'd0, 19'h00000, 32'h04030201);
    serve("rr.x2", 2'd1, 19'h14000, 32'h14131211);
    serve("rr.x4", 2'd2, 19'h19000, 32'h24232221);
    quiet("rr.quiet", 4);

    // frame_start on the third pixel discards the partial word and realigns.
    drive(3'b001, 8'h55, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'h66, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'hAA, 8'h00, 8'h00, 1'b1);
    drive(3'b001, 8'hBB, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'hCC, 8'h00, 8'h00, 1'b0);
    drive(3'b001, 8'hDD, 8'h00, 8'h00, 1'b0);
    serve("fs.word", 2'd0, 19'h00000, 32'hDDCCBBAA);
    quiet("fs.quiet", 6);

    // Five x4 words into a 4-deep FIFO with memory stalled.
    do_reset();
    for (int w = 0; w < 5; w++)
      for (int p = 0; p < 4; p++)
        drive(3'b100, 8'h00, 8'h00, 8'(8'hA0 + w), 1'b0);
    step();
    step();
    step();
    check("ovf.x4", 32'(ovf_4), 32'd1);
    check("ovf.x1x2", 32'({ovf_1, ovf_2}), 32'd0);
    serve("ovf.w0", 2'd2, 19'h19000, 32'hA0A0A0A0);
    serve("ovf.w1", 2'd2, 19'h19001, 32'hA1A1A1A1);
    serve("ovf.w2", 2'd2, 19'h19002, 32'hA2A2A2A2);
    serve("ovf.w3", 2'd2, 19'h19003, 32'hA3A3A3A3);
    quiet("ovf.gone", 4);
    for (int p = 0; p < 4; p++)
      drive(3'b100, 8'h00, 8'h00, 8'hA5, 1'b0);
    serve("ovf.w5", 2'd2, 19'h19005, 32'hA5A5A5A5);
    check("ovf.sticky", 32'(ovf_4), 32'd1);

    // Full x4 frame: 40*120 words, memory always ready.
    do_reset();
    mem_ack = 1'b1;
    done_cnt = 0;
    done_pix = -1;
    last_addr = '0;
    for (int w = 0; w < 4800; w++)
      for (int p = 0; p < 4; p++) begin
        drive(3'b100, 8'h00, 8'h00, 8'(w + p), 1'b0);
        if (frame_done_4) begin
          done_cnt++;
          done_pix = w * 4 + p;
        end
        if (mem_req) last_addr = mem_addr;
      end
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame_done_4) done_cnt++;
      if (mem_req) last_addr = mem_addr;
    end
    mem_ack = 1'b0;
    check("frm.done_cnt", 32'(done_cnt), 32'd1);
    check("frm.done_pix", 32'(done_pix), 32'd19199);
    check("frm.last_addr", 32'(last_addr), 32'h1A2BF);
    check("frm.ovf", 32'(ovf_4), 32'd0);
    for (int p = 0; p < 4; p++)
      drive(3'b100, 8'h00, 8'h00, 8'h5A, 1'b0);
    serve("frm.wrap", 2'd2, 19'h19000, 32'h5A5A5A5A);

    // Reset while a request is pending and more words are queued.
    for (int p = 0; p < 4; p++)
      drive(3'b011, 8'h77, 8'h88, 8'h00, 1'b0);
    begin
      int n = 0;
      while (!mem_req && n < 40) begin
        step();
        n++;
      end
    end
    check("rstb.busy", 32'(mem_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstb.req_async", 32'(mem_req), 32'd0);
    check("rstb.data_async", mem_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    quiet("rstb.empty", 10);
    for (int p = 0; p < 4; p++)
      drive(3'b001, 8'(8'hC1 + p), 8'h00, 8'h00, 1'b0);
    serve("rstb.fresh", 2'd0, 19'h00000, 32'hC4C3C2C1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scld_pix_packer.md
SCLD_PIX_PACKER -- requirements
Module: scld_pix_packer

Interface
REQ-001 Parameter H_PIX, default 640, full-scale pixels per line; SHALL be a multiple of 16.
REQ-002 Parameter V_LINES, default 480, full-scale lines per frame; SHALL be a multiple of 4.
REQ-003 Parameter BASE_1 / BASE_2 / BASE_4, defaults 19'h00000 / 19'h14000 / 19'h19000, word base address per scale.
REQ-004 Parameter FIFO_DEPTH, default 4, words per per-scale FIFO; power of 2.
REQ-005 tm3_clk_v0  in  1  sole clock; all state changes on its rising edge.
REQ-006 tm3_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 vidin_frame_start  in  1  one-cycle pulse marking start of a new frame.
REQ-008 vidin_new_data_scld_1 / _2 / _4  in  1 each  pixel-valid strobes from scaler.
REQ-009 vidin_gray_scld_1 / _2 / _4  in  8 each  gray pixels, valid when matching strobe is high.
REQ-010 mem_req  out  1  write request.
REQ-011 mem_ack  in  1  memory accepts the current request.
REQ-012 mem_addr  out  19  word address; mem_data  out  32  packed word; mem_scale  out  2  source scale (0=x1, 1=x2, 2=x4).
REQ-013 frame_done_1 / _2 / _4  out  1 each  one-cycle pulse when the last word of a frame for that scale enters its FIFO.
REQ-014 ovf_1 / ovf_2 / ovf_4  out  1 each  sticky overflow flags.

Function
REQ-015 Each scale SHALL pack 4 consecutive valid pixels little-endian: first pixel in [7:0], fourth in [31:24].
REQ-016 A completed word SHALL be pushed into that scale's FIFO the cycle after the fourth pixel is sampled, with address BASE_s + running word index.
REQ-017 Word index SHALL wrap to 0 after (H_PIX/s/4)*(V_LINES/s) words; the push of the final index SHALL pulse frame_done_s in the same cycle.
REQ-018 vidin_frame_start SHALL clear every packer byte count and word index; partial words are discarded; FIFO contents are kept and still written.
REQ-019 frame_start coincident with a valid pixel: clear first, then that pixel becomes byte 0 of word 0.
REQ-020 Push into a full FIFO SHALL drop the word, set ovf_s, and still advance the word index; a pop in the same cycle counts as freeing space first.
REQ-021 Arbiter states IDLE and BUSY. IDLE: if any FIFO is non-empty, select round-robin (order x1, x2, x4, starting after the last granted scale; x1 first after reset), load outputs, go BUSY.
REQ-022 BUSY: mem_req=1; mem_addr/mem_data/mem_scale SHALL stay stable until mem_ack sampled high; on ack pop the FIFO, drop mem_req, return IDLE.
REQ-023 Minimum spacing: one IDLE cycle between consecutive requests; ack latency unbounded.
REQ-024 Pixel-in to mem_req latency with empty FIFOs and memory idle: 3 cycles after the fourth pixel.
REQ-025 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-026 On tm3_rst_n low: mem_req=0, mem_addr=0, mem_data=0, mem_scale=0, frame_done_*=0, ovf_*=0, FIFOs empty, counters 0, arbiter IDLE with x1 next.
REQ-027 Reset mid-request SHALL abandon the request; no word is popped or retried.
REQ-028 Reset release takes effect synchronously; first request possible no earlier than 3 cycles after release plus 4 pixels.

Structure
REQ-029 Shared package SHALL hold scale encodings (2-bit), address width 19, and the BASE_* defaults.
REQ-030 One sub-module, scld_word_fifo (32-bit data + 19-bit address, FIFO_DEPTH entries, full/empty), instantiated three times.

Verification
REQ-031 Reset, then 4 x1 pixels 8'h11,22,33,44 with mem_ack tied high -> one request: mem_data=32'h44332211, mem_addr=19'h00000, mem_scale=0, 3 cycles after the fourth pixel.
REQ-032 Simultaneous complete words on all scales, mem_ack after 2 cycles of req each -> grant order x1, x2, x4; addresses 0, 19'h14000, 19'h19000; addr/data stable throughout each request.
REQ-033 mem_ack held low, 5 x4 words pushed (FIFO_DEPTH=4) -> ovf_4=1, 5th word absent from later writes, index still advanced (6th word address 19'h19005).
REQ-034 Stream a full x4 frame (40*120 words) -> frame_done_4 pulses once at word 4799; next word address wraps to 19'h19000.
REQ-035 frame_start after 2 x1 pixels, coincident with pixel 8'hAA, then 3 more pixels -> first word data [7:0]=8'hAA, address 19'h00000; earlier partial word never written.
REQ-036 Assert tm3_rst_n low during BUSY with mem_ack low -> mem_req drops asynchronously; all FIFOs empty after release.
